imem_prog_loader: RTL
=====================

// Module: imem_prog_loader
// PURPOSE
//  Write-side counterpart of the MIPS instruction memory: receives a byte stream (length header + payload),
//  writes bytes big-endian into the byte-wide instruction memory starting at BASE_ADDR, and holds the
//  CPU in reset (cpu_reset_n low) until the image is complete, so the first fetch sees the new program.
// PARAMETERS
//  MEM_SIZE   100   instruction memory size in bytes; largest accepted payload
//  ADDR_W     7     width of mem_addr; must satisfy 2**ADDR_W >= MEM_SIZE
//  BASE_ADDR  0     byte address of the first payload byte
//  TIMEOUT    1000  max idle cycles between accepted bytes while loading; 0 disables the timeout
// PORTS
//  clk          in   1       clock, all logic on rising edge
//  reset        in   1       synchronous, active-high reset
//  start        in   1       1-cycle pulse: begin a new load (ignored while loading)
//  rx_valid     in   1       rx_data valid
//  rx_data      in   8       stream byte
//  rx_ready     out  1       loader accepts a byte this cycle (transfer = rx_valid & rx_ready)
//  mem_we       out  1       instruction memory byte write strobe
//  mem_addr     out  ADDR_W  byte address of the write
//  mem_wdata    out  8       byte to write
//  cpu_reset_n  out  1       active-low reset to the CPU (pc/registers); high only in DONE
//  busy         out  1       load in progress
//  done         out  1       image loaded successfully (level, held in DONE)
//  err          out  1       load failed (level, held in ERR)
// BEHAVIOUR
//  Reset (sync): state IDLE; rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset_n=0, busy=0, done=0, err=0.
//  States: IDLE, LEN_HI, LEN_LO, DATA, CSUM (macro only), DONE, ERR. All outputs registered.
//  IDLE/DONE/ERR: start=1 -> LEN_HI; clears done/err, cpu_reset_n=0, busy=1, byte counter and checksum cleared.
//  LEN_HI: accept byte -> len[15:8]; -> LEN_LO.  LEN_LO: accept byte -> len[7:0], then check:
//   len > MEM_SIZE or len[1:0]!=0 -> ERR; len==0 -> DONE (CSUM if macro); else -> DATA, addr=BASE_ADDR.
//  DATA: each accepted byte produces mem_we=1 exactly one cycle later with mem_addr=BASE_ADDR+cnt,
//   mem_wdata=byte; cnt increments per byte; after byte len-1 -> DONE (CSUM if macro). mem_we is a
//   single-cycle pulse per byte; back-to-back bytes give back-to-back writes (1 byte/cycle throughput).
//  rx_ready=1 in LEN_HI, LEN_LO, DATA, CSUM; 0 in IDLE, DONE, ERR and in the cycle the last expected byte
//   is accepted (no over-acceptance). Byte order: first payload byte = instruction bits [31:24].
//  Timeout: idle counter resets on every accepted byte and on start; counts while rx_ready=1 and no
//   transfer; reaching TIMEOUT -> ERR. TIMEOUT=0: counter disabled.
//  DONE: cpu_reset_n=1, done=1, busy=0. ERR: cpu_reset_n=0, err=1, busy=0 (CPU stays held).
//  Address arithmetic ADDR_W bits, never wraps (len<=MEM_SIZE guaranteed before DATA).
//  Reset mid-load: returns to IDLE next edge, pending mem_we dropped, already-written bytes left as is.
//  start during LEN_HI..CSUM: ignored. start and reset same cycle: reset wins.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined: one trailing byte after payload (CSUM state); required such that the
//   8-bit sum of len hi, len lo, all payload bytes and trailer == 8'h00; match -> DONE, mismatch -> ERR.
//   Trailer is never written to memory.
//  Undefined: no CSUM state, no trailer; DATA (or len==0) goes directly to DONE.
// TESTING
//  1 reset, start, stream 00 04 34 08 00 0B (every cycle) -> writes addr0..3 = 34,08,00,0B on 4 consecutive
//    cycles, done=1, cpu_reset_n=1, busy=0; with macro append trailer 8'hB5 for same result.
//  2 len 00 65 (101 > MEM_SIZE) -> err=1 after LEN_LO, no mem_we ever, cpu_reset_n=0; len 00 06 -> err=1.
//  3 rx_valid gaps of 3 cycles between bytes of 8-byte image -> same 8 writes, rx_ready never low mid-load.
//  4 TIMEOUT=16: stop after 2 payload bytes -> err=1 exactly 16 cycles after last transfer; start then
//    reload -> done=1.
//  5 reset asserted after 3rd payload byte -> IDLE next edge, mem_we=0, all outputs at reset values;
//    macro on: wrong trailer (B4 in test 1) -> err=1, cpu_reset_n=0.
//  6 len 00 00 -> done=1 with zero writes; start pulses during DATA ignored; extra rx_valid after
//    last byte not accepted (rx_ready=0).

Source files
------------

// File: rtl/imem_prog_loader.sv
// imem_prog_loader: streams a length-prefixed program image into the byte-wide
// MIPS instruction memory (big-endian, starting at BASE_ADDR) and holds the CPU
// in reset until the whole image has landed.
// Optional feature macro: LOADER_CHECKSUM_EN adds one trailing checksum byte
// (8-bit sum of header, payload and trailer must be zero).
module imem_prog_loader #(
  parameter int MEM_SIZE  = 100,
  parameter int ADDR_W    = 7,
  parameter int BASE_ADDR = 0,
  parameter int TIMEOUT   = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_reset_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  // State entered once the payload (or an empty image) is complete.
`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CSUM;
`else
  localparam state_t S_TAIL = S_DONE;
`endif

  // Idle counter only has to hold TIMEOUT-1; the wrap to ERR happens on that value.
  localparam int                IDLE_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [15:0]       MAX_LEN   = 16'(MEM_SIZE);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [7:0]        sum_q, sum_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [7:0]        mem_wdata_d;
  logic              busy_d;
  logic              xfer;
  logic [15:0]       len_rx;
  logic [7:0]        sum_rx;

  // Next-state, counters and next values of every registered output.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    idle_d      = '0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    xfer        = rx_valid & rx_ready;
    len_rx      = {len_q[15:8], rx_data};
    sum_rx      = sum_q + rx_data;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN_HI;
          len_d   = '0;
          cnt_d   = '0;
          sum_d   = '0;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = rx_data;
          sum_d       = sum_rx;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d = len_rx;
          sum_d = sum_rx;
          if (len_rx > MAX_LEN || len_rx[1:0] != 2'b00) state_d = S_ERR;
          else if (len_rx == 16'd0)                     state_d = S_TAIL;
          else                                          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = BASE + cnt_q[ADDR_W-1:0];
          mem_wdata_d = rx_data;
          cnt_d       = cnt_q + 16'd1;
          sum_d       = sum_rx;
          if (cnt_q == len_q - 16'd1) state_d = S_TAIL;
        end
      end
      S_CSUM: begin
        if (xfer) state_d = (sum_rx == 8'h00) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase

    // Stall watchdog: only runs while the loader is asking for a byte.
    if (TIMEOUT != 0 && rx_ready && !xfer) begin
      if (idle_q == IDLE_LAST) state_d = S_ERR;
      else                     idle_d  = idle_q + 1'b1;
    end

    busy_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
             (state_d == S_DATA)   || (state_d == S_CSUM);
  end

  // State, counters and all outputs registered; reset wins over start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      idle_q      <= '0;
      rx_ready    <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cpu_reset_n <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      idle_q      <= idle_d;
      rx_ready    <= busy_d;
      mem_we      <= mem_we_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
      cpu_reset_n <= (state_d == S_DONE);
      busy        <= busy_d;
      done        <= (state_d == S_DONE);
      err         <= (state_d == S_ERR);
    end
  end

endmodule
